// File: rtl/hci_core_read_arbiter_if.sv
// Bundle for an HCI core TCDM port. N lanes of request and payload, one grant
// and one response-valid bit per lane, and one response data word shared by
// all lanes. The arbiter uses N=NB_REQ on its upstream side and N=1 on its
// downstream side.
interface hci_core_read_arbiter_if #(
  parameter int N  = 4,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N-1:0]                req;
  logic [N-1:0][AW-1:0]        add;
  logic [N-1:0]                wen;
  logic [N-1:0][DW-1:0]        data;
  logic [N-1:0][DW/8-1:0]      be;
  logic [N-1:0]                gnt;
  logic [N-1:0]                r_valid;
  logic [DW-1:0]               r_data;

  modport master (output req, add, wen, data, be, input  gnt, r_valid, r_data);
  modport slave  (input  req, add, wen, data, be, output gnt, r_valid, r_data);
endinterface

// File: rtl/hci_core_read_arbiter.sv
// Round-robin arbiter that shares one HCI core TCDM port between NB_REQ
// requesters. The ID of each granted read goes into a FIFO. Each downstream
// r_valid pops the FIFO head, which steers the response back to the
// requester that issued that read.
module hci_core_read_arbiter #(
  parameter int NB_REQ  = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  localparam int CW     = $clog2(MAX_OUT+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  hci_core_read_arbiter_if.slave  up,
  hci_core_read_arbiter_if.master dn,
  output logic [CW-1:0]        outstanding_o,
  output logic                 err_o
);
  localparam int IDW = $clog2(NB_REQ);
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [IDW-1:0]                ptr_q;
  logic [CW-1:0]                 cnt_q;
  logic [PW-1:0]                 rd_q, wr_q;
  logic [MAX_OUT-1:0][IDW-1:0]   fifo_q;
  logic                          err_q;

  logic                          full, empty, any, hs, push, pop_v, pop;
  logic [NB_REQ-1:0]             elig;
  logic [IDW-1:0]                win, head;

  assign full  = (cnt_q == CW'(MAX_OUT));
  assign empty = (cnt_q == '0);
  // A read cannot be issued while the ID FIFO is full. A pop in the same
  // cycle does not lift the stall. Writes never push, so they are never
  // masked.
  assign elig  = up.req & ~({NB_REQ{full}} & up.wen);
  assign any   = |elig;

  // Winner is the first eligible requester found by scanning up from the
  // pointer, wrapping past the last requester back to 0.
  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Downstream request and payload. Held at zero while reset is asserted.
  assign dn.req[0]  = any & rst_ni;
  assign dn.add[0]  = up.add[win];
  assign dn.wen[0]  = up.wen[win];
  assign dn.data[0] = up.data[win];
  assign dn.be[0]   = up.be[win];

  assign hs     = dn.req[0] & dn.gnt[0];
  assign up.gnt = hs ? (NB_REQ'(1) << win) : '0;

  // Responses return with zero latency and go to the requester at the FIFO head.
  assign head       = fifo_q[rd_q];
  assign pop_v      = dn.r_valid[0] & ~empty & rst_ni;
  assign up.r_valid = pop_v ? (NB_REQ'(1) << head) : '0;
  assign up.r_data  = dn.r_data;

  // clear_i lets the grant through combinationally, but no ID is recorded for it.
  assign push = hs & up.wen[win] & ~clear_i;
  assign pop  = pop_v & ~clear_i;

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT-1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pointer advances past the winner on every handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       ptr_q <= '0;
    else if (clear_i)  ptr_q <= '0;
    else if (hs)       ptr_q <= (win == IDW'(NB_REQ-1)) ? '0 : win + IDW'(1);
  end

  // ID FIFO: storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= win;
        wr_q         <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Sticky error: a response arrived when no read was outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        err_q <= 1'b0;
    else if (clear_i)                   err_q <= 1'b0;
    else if (dn.r_valid[0] && empty)    err_q <= 1'b1;
  end
endmodule
